// File: rtl/zoom_ctrl_pkg.sv
// Shared definitions for the zoom command sequencer: FSM encoding,
// algorithm select values and the zoom-level width.
package zoom_ctrl_pkg;

  localparam int ZOOM_W = 3;

  localparam logic ALG_NEAREST = 1'b0;
  localparam logic ALG_SMOOTH  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/zoom_ctrl_edge_rise.sv
// Rising-edge detector for one debounced button level: one history register
// plus a registered single-cycle press pulse.
module edge_rise (
  input  logic CLK,
  input  logic RESET,
  input  logic level,
  output logic rise
);

  logic level_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      level_q <= 1'b0;
      rise    <= 1'b0;
    end else begin
      level_q <= level;
      rise    <= level & ~level_q;
    end
  end

endmodule

// File: rtl/zoom_ctrl.sv
// Zoom command sequencer: turns button presses into saturating zoom/algorithm
// changes and hands each one to the datapath with a start/done handshake.
module zoom_ctrl
  import zoom_ctrl_pkg::*;
#(
  parameter int MAX_IN  = 2,
  parameter int MAX_OUT = 2,
  parameter int TIMEOUT = 50_000_000
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     btn_in,
  input  logic                     btn_out,
  input  logic                     btn_mode,
  input  logic                     done,
  output logic signed [ZOOM_W-1:0] zoom_level,
  output logic                     alg_sel,
  output logic                     start,
  output logic                     busy,
  output logic                     err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic signed [ZOOM_W-1:0] LVL_HI = ZOOM_W'(MAX_IN);
  localparam logic signed [ZOOM_W-1:0] LVL_LO = ZOOM_W'(-MAX_OUT);

  function automatic logic at_ceiling(input logic signed [ZOOM_W-1:0] lvl);
    return lvl >= LVL_HI;
  endfunction

  function automatic logic at_floor(input logic signed [ZOOM_W-1:0] lvl);
    return lvl <= LVL_LO;
  endfunction

  state_t state, state_nxt;

  logic ev_in, ev_out, ev_mode;
  logic p_in, p_out, p_mode;
  logic clr_in, clr_out, clr_mode;
  logic take_in, take_out, take_mode;
  logic timeout;
  logic [CNT_W-1:0] cnt;
  logic signed [ZOOM_W-1:0] saved_level;
  logic saved_alg;

  edge_rise u_edge_in   (.CLK(CLK), .RESET(RESET), .level(btn_in),   .rise(ev_in));
  edge_rise u_edge_out  (.CLK(CLK), .RESET(RESET), .level(btn_out),  .rise(ev_out));
  edge_rise u_edge_mode (.CLK(CLK), .RESET(RESET), .level(btn_mode), .rise(ev_mode));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // A saturated request is cleared but not taken; the FSM stays in IDLE so the
  // next pending bit is served on the following cycle.
  always_comb begin
    state_nxt = state;
    clr_in    = 1'b0;
    clr_out   = 1'b0;
    clr_mode  = 1'b0;
    take_in   = 1'b0;
    take_out  = 1'b0;
    take_mode = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (p_out) begin
          clr_out = 1'b1;
          if (!at_floor(zoom_level)) begin
            take_out  = 1'b1;
            state_nxt = ISSUE;
          end
        end else if (p_in) begin
          clr_in = 1'b1;
          if (!at_ceiling(zoom_level)) begin
            take_in   = 1'b1;
            state_nxt = ISSUE;
          end
        end else if (p_mode) begin
          clr_mode  = 1'b1;
          take_mode = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (done) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start = (state == ISSUE);
    busy  = (state == ISSUE) || (state == WAIT);
  end

  // A new press arriving in the same cycle its bit is cleared keeps it set.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      p_in        <= 1'b0;
      p_out       <= 1'b0;
      p_mode      <= 1'b0;
      zoom_level  <= '0;
      alg_sel     <= ALG_NEAREST;
      saved_level <= '0;
      saved_alg   <= ALG_NEAREST;
      err         <= 1'b0;
      cnt         <= '0;
    end else begin
      p_in   <= (p_in   & ~clr_in)   | ev_in;
      p_out  <= (p_out  & ~clr_out)  | ev_out;
      p_mode <= (p_mode & ~clr_mode) | ev_mode;

      if (take_in || take_out || take_mode) begin
        saved_level <= zoom_level;
        saved_alg   <= alg_sel;
      end

      if (take_in)       zoom_level <= zoom_level + ZOOM_W'(1);
      else if (take_out) zoom_level <= zoom_level - ZOOM_W'(1);
      else if (timeout)  zoom_level <= saved_level;

      if (take_mode)    alg_sel <= (alg_sel == ALG_SMOOTH) ? ALG_NEAREST : ALG_SMOOTH;
      else if (timeout) alg_sel <= saved_alg;

      if (timeout)                     err <= 1'b1;
      else if (state == WAIT && done)  err <= 1'b0;

      if (state == ISSUE)     cnt <= '0;
      else if (state == WAIT) cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_zoom_ctrl.sv
// Self-checking bench for zoom_ctrl: directed scenarios plus a randomized
// press/handshake sequence compared against a transaction-level model.
module tb_zoom_ctrl;

  localparam int TO = 16;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic [2:0] btns = 3'b000;   // [0]=in, [1]=out, [2]=mode
  logic done = 1'b0;
  logic signed [2:0] zoom_level;
  logic alg_sel, start, busy, err;

  int tests_run = 0;
  int fails = 0;

  zoom_ctrl #(.MAX_IN(2), .MAX_OUT(2), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET(RESET),
    .btn_in(btns[0]), .btn_out(btns[1]), .btn_mode(btns[2]),
    .done(done),
    .zoom_level(zoom_level), .alg_sel(alg_sel),
    .start(start), .busy(busy), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic do_reset();
    @(negedge CLK);
    btns = 3'b000;
    done = 1'b0;
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
  endtask

  // Drive mask, release after 'hold' negedges; returns negedges until start (-1 if none in 12).
  task automatic press_and_wait(input logic [2:0] mask, input int hold, output int lat);
    lat = -1;
    btns = mask;
    for (int i = 1; i <= 12; i++) begin
      @(negedge CLK);
      done = 1'b0;
      if (i >= hold) btns = 3'b000;
      if (start) begin
        lat = i;
        break;
      end
    end
    btns = 3'b000;
  endtask

  // Called at the negedge where start is seen; d=0 means never answer.
  task automatic handshake(input int d, output int busy_cnt);
    busy_cnt = 0;
    for (int i = 0; i <= 40; i++) begin
      if (busy) busy_cnt++;
      else break;
      done = (d > 0 && i == d);
      @(negedge CLK);
    end
    done = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    tests_run++;
    if ({zoom_level, alg_sel, start, busy, err} !== 7'b0) begin
      fails++;
      $display("FAIL reset_outputs: got lvl=%0d alg=%b start=%b busy=%b err=%b, want all 0",
               zoom_level, alg_sel, start, busy, err);
    end
    RESET = 1'b0;
  endtask

  task automatic test_single_in();
    int lat, bc;
    do_reset();
    press_and_wait(3'b001, 1, lat);
    tests_run++;
    if (lat !== 3) begin fails++; $display("FAIL single_latency: got %0d want 3", lat); end
    tests_run++;
    if (int'(zoom_level) !== 1) begin fails++; $display("FAIL single_level: got %0d want 1", zoom_level); end
    handshake(2, bc);
    tests_run++;
    if (bc !== 3) begin fails++; $display("FAIL single_busy_cycles: got %0d want 3", bc); end
    tests_run++;
    if (err !== 1'b0 || int'(zoom_level) !== 1) begin
      fails++; $display("FAIL single_after: got err=%b lvl=%0d want err=0 lvl=1", err, zoom_level);
    end
  endtask

  task automatic test_saturate();
    int lat, bc;
    do_reset();
    press_and_wait(3'b001, 2, lat);
    handshake(1, bc);
    press_and_wait(3'b001, 2, lat);
    tests_run++;
    if (lat !== 3 || int'(zoom_level) !== 2) begin
      fails++; $display("FAIL sat_second: got lat=%0d lvl=%0d want 3/2", lat, zoom_level);
    end
    handshake(1, bc);
    press_and_wait(3'b001, 2, lat);
    tests_run++;
    if (lat !== -1 || int'(zoom_level) !== 2) begin
      fails++; $display("FAIL sat_third: got lat=%0d lvl=%0d want no start, lvl 2", lat, zoom_level);
    end
  endtask

  task automatic test_same_cycle();
    int lat, bc;
    do_reset();
    press_and_wait(3'b011, 1, lat);
    tests_run++;
    if (lat !== 3 || int'(zoom_level) !== -1) begin
      fails++; $display("FAIL same_first: got lat=%0d lvl=%0d want 3/-1", lat, zoom_level);
    end
    handshake(1, bc);
    press_and_wait(3'b000, 1, lat);
    tests_run++;
    if (lat === -1 || int'(zoom_level) !== 0) begin
      fails++; $display("FAIL same_second: got lat=%0d lvl=%0d want start with lvl 0", lat, zoom_level);
    end
    handshake(1, bc);
  endtask

  task automatic test_mode_collapse();
    int lat, bc;
    do_reset();
    press_and_wait(3'b100, 1, lat);
    tests_run++;
    if (lat !== 3 || alg_sel !== 1'b1) begin
      fails++; $display("FAIL mode_first: got lat=%0d alg=%b want 3/1", lat, alg_sel);
    end
    for (int i = 1; i <= 8; i++) begin
      @(negedge CLK);
      btns[2] = (i == 1 || i == 3);
      done = (i == 8);
    end
    press_and_wait(3'b000, 1, lat);
    tests_run++;
    if (lat === -1 || alg_sel !== 1'b0) begin
      fails++; $display("FAIL mode_second: got lat=%0d alg=%b want start with alg 0", lat, alg_sel);
    end
    handshake(1, bc);
    press_and_wait(3'b000, 1, lat);
    tests_run++;
    if (lat !== -1) begin fails++; $display("FAIL mode_no_third: got start at %0d want none", lat); end
  endtask

  task automatic test_timeout();
    int lat, bc, wcnt;
    do_reset();
    press_and_wait(3'b010, 1, lat);
    tests_run++;
    if (lat !== 3 || int'(zoom_level) !== -1) begin
      fails++; $display("FAIL to_start: got lat=%0d lvl=%0d want 3/-1", lat, zoom_level);
    end
    wcnt = 0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge CLK);
      if (busy && int'(zoom_level) == -1) wcnt++;
      else break;
    end
    tests_run++;
    if (wcnt !== TO) begin fails++; $display("FAIL to_wait_cycles: got %0d want %0d", wcnt, TO); end
    tests_run++;
    if (int'(zoom_level) !== 0 || err !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL to_rollback: got lvl=%0d err=%b busy=%b want 0/1/0", zoom_level, err, busy);
    end
    press_and_wait(3'b001, 1, lat);
    tests_run++;
    if (lat !== 3 || err !== 1'b1) begin
      fails++; $display("FAIL to_err_sticky: got lat=%0d err=%b want 3/1", lat, err);
    end
    handshake(1, bc);
    tests_run++;
    if (err !== 1'b0 || int'(zoom_level) !== 1) begin
      fails++; $display("FAIL to_err_clear: got err=%b lvl=%0d want 0/1", err, zoom_level);
    end
  endtask

  task automatic test_done_at_terminal();
    int lat, bc;
    do_reset();
    press_and_wait(3'b001, 1, lat);
    handshake(TO, bc);
    tests_run++;
    if (bc !== TO + 1 || int'(zoom_level) !== 1 || err !== 1'b0) begin
      fails++; $display("FAIL done_terminal: got busy=%0d lvl=%0d err=%b want %0d/1/0",
                        bc, zoom_level, err, TO + 1);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    do_reset();
    press_and_wait(3'b010, 1, lat);
    @(negedge CLK); btns = 3'b001;
    @(negedge CLK); btns = 3'b000;
    @(negedge CLK);
    #2 RESET = 1'b1;
    #1;
    tests_run++;
    if ({zoom_level, alg_sel, start, busy, err} !== 7'b0) begin
      fails++; $display("FAIL reset_mid: got lvl=%0d alg=%b start=%b busy=%b err=%b want all 0",
                        zoom_level, alg_sel, start, busy, err);
    end
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    press_and_wait(3'b000, 1, lat);
    tests_run++;
    if (lat !== -1) begin fails++; $display("FAIL reset_mid_no_start: got start at %0d want none", lat); end
  endtask

  task automatic test_random();
    int m_level, exp_level, lat, bc, b, hold, d, exp_bc;
    logic m_alg, m_err, exp_alg;
    bit sat, to;
    do_reset();
    m_level = 0; m_alg = 1'b0; m_err = 1'b0;
    for (int it = 0; it < 40; it++) begin
      b = $urandom_range(0, 2);
      hold = $urandom_range(1, 3);
      sat = (b == 0 && m_level == 2) || (b == 1 && m_level == -2);
      press_and_wait(3'(1 << b), hold, lat);
      if (sat) begin
        tests_run++;
        if (lat !== -1 || int'(zoom_level) !== m_level || err !== m_err) begin
          fails++; $display("FAIL rand_sat it=%0d: got lat=%0d lvl=%0d err=%b want none/%0d/%b",
                            it, lat, zoom_level, err, m_level, m_err);
        end
        continue;
      end
      exp_level = m_level + (b == 0 ? 1 : 0) - (b == 1 ? 1 : 0);
      exp_alg = m_alg ^ (b == 2);
      tests_run++;
      if (lat !== 3 || int'(zoom_level) !== exp_level || alg_sel !== exp_alg) begin
        fails++; $display("FAIL rand_start it=%0d: got lat=%0d lvl=%0d alg=%b want 3/%0d/%b",
                          it, lat, zoom_level, alg_sel, exp_level, exp_alg);
      end
      to = ($urandom_range(0, 4) == 0);
      d = to ? 0 : $urandom_range(1, 4);
      exp_bc = to ? TO + 1 : d + 1;
      handshake(d, bc);
      if (to) m_err = 1'b1;
      else begin m_level = exp_level; m_alg = exp_alg; m_err = 1'b0; end
      tests_run++;
      if (bc !== exp_bc || int'(zoom_level) !== m_level || alg_sel !== m_alg || err !== m_err) begin
        fails++; $display("FAIL rand_end it=%0d: got busy=%0d lvl=%0d alg=%b err=%b want %0d/%0d/%b/%b",
                          it, bc, zoom_level, alg_sel, err, exp_bc, m_level, m_alg, m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_in();
    test_saturate();
    test_same_cycle();
    test_mode_collapse();
    test_timeout();
    test_done_at_terminal();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
